hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the pipelined core. It replaces the fixed load-use stall equation and the fixed MX/WX bypass compares in the top level. A per-register scoreboard tracks in-flight writers by age and result latency. From that it produces the decode-stage stall and registered per-source forward selects for the execute-stage operand muxes. It generalises to deeper pipelines (NUM_FWD bypass stages), any number of source operands, and per-instruction result latency.

Parameters:
NUM_REGS, 32, architectural registers; register 0 is hardwired zero
REG_AW, 5, register index width, equal to clog2(NUM_REGS)
NUM_SRC, 2, source operands per instruction
NUM_FWD, 2, bypass stages after execute (1 = X/M, 2 = M/W, ...)
SEL_W, 2, forward-select width, equal to clog2(NUM_FWD+1)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low
issue_valid  in  1  valid instruction in decode
src_reg  in  NUM_SRC*REG_AW  source register indices, source i in slice i
src_used  in  NUM_SRC  source i is actually read
dst_reg  in  REG_AW  destination register
dst_we  in  1  instruction writes dst_reg
dst_lat  in  SEL_W  result latency in stages after execute entry (ALU=1, load=2)
flush  in  1  taken branch/jump resolved in execute; kill decode instruction
stall  out  1  hold fetch/decode, inject bubble into execute
issue_fire  out  1  decode instruction advances this edge
fwd_sel  out  NUM_SRC*SEL_W  registered; 0 = regfile, k = bypass from stage k
stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Reset (rst low, asynchronous): every busy flag 0, fwd_sel 0, stall_cnt 0. Reset mid-operation discards all tracked writers.
- Per-register entry r (1..NUM_REGS-1) holds busy, age (1..NUM_FWD) and lat. Register 0 is never busy.
- dst_lat of 0 or greater than NUM_FWD is clamped to NUM_FWD.
- Aging on every edge, for each busy entry: if age==NUM_FWD then busy<=0, else age<=age+1.
- Issue on an edge with issue_fire and dst_we and dst_reg!=0: entry[dst_reg] gets busy=1, age=1, lat=dst_lat.
  - Issue overrides aging of the same entry, so the youngest writer wins (WAW).
- Hazard for source i: src_used[i] and src_reg[i]!=0 and busy[src_reg[i]] and age < lat.
- stall = issue_valid and not flush and (any source hazard). This is combinational.
- issue_fire = issue_valid and not flush and not stall.
- Per-source path d_i:
  - d_i = age when busy and age >= lat.
  - d_i = 0 otherwise, including not busy, unused source, or register 0.
- fwd_sel update:
  - On an edge with issue_fire: fwd_sel[i] <= d_i. The value is valid while the instruction is in execute.
  - On an edge without issue_fire (stall, flush or no valid): fwd_sel <= 0 (bubble).
- flush has priority over issue and hazard. The decode instruction creates no entry. Existing entries keep aging.
- stall_cnt increments on each edge with stall=1 and saturates at 0xFFFFFFFF.
- Latency from inputs to stall and issue_fire is zero cycles; fwd_sel has one cycle of latency.
- Store-data late consumption is out of scope: store data follows the normal rule, which is conservative.

Decomposition:
- Shared package proc_pkg holds:
  - FWD_RF=0, FWD_XM=1, FWD_MW=2
  - LAT_ALU=1, LAT_LOAD=2
  - a sb_entry_t struct {busy, age, lat}
- One natural sub-module, sb_entry: a single register's busy/age/lat flops with aging, issue-load and clear logic. It is generated for registers 1..NUM_REGS-1.
- Hazard compare, stall, fwd_sel and stall_cnt logic stay in hazard_scoreboard.

Test Plan:
1. ALU writes r3 (lat 1), then the next instruction reads r3 as src0 -> stall=0, fwd_sel[0]=1 in the following cycle, stall_cnt=0.
2. Load writes r5 (lat 2), then the next instruction reads r5 as src1 -> stall=1 for exactly one cycle, stall_cnt=1; after the bubble, fwd_sel[1]=2.
3. ALU writes r7, one independent instruction follows, then an instruction reads r7 -> fwd_sel=2. With two independent instructions between them -> fwd_sel=0, entry cleared.
4. Load writes r0, then the next instruction reads r0 -> stall=0, fwd_sel=0. flush=1 during a load to r4, then an instruction reads r4 -> no stall, fwd_sel=0, issue_fire=0 on the flush cycle.
5. Load writes r6, ALU writes r6, then an instruction reads r6 -> stall=0, fwd_sel=1 (youngest writer). Assert rst mid-stream -> all outputs 0 immediately.
6. NUM_FWD=3 build: instruction with lat 3 to r2, then the next instruction reads r2 -> two stall cycles, fwd_sel=3, stall_cnt=2.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and the per-register scoreboard entry type used by the hazard logic.
package proc_pkg;

    localparam int FWD_RF   = 0;
    localparam int FWD_XM   = 1;
    localparam int FWD_MW   = 2;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    // Entry fields are sized for bypass depths up to 15 so one type serves every build.
    localparam int ENT_W    = 4;

    typedef struct packed {
        logic             busy;
        logic [ENT_W-1:0] age;
        logic [ENT_W-1:0] lat;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One architectural register's in-flight writer record: issue-load, aging and retirement.
module sb_entry
    import proc_pkg::*;
#(
    parameter int NUM_FWD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ENT_W-1:0] lat,
    output sb_entry_t        ent
);

    localparam logic [ENT_W-1:0] AGE_MAX = ENT_W'(NUM_FWD);

    // A new issue to this register replaces the older writer outright (youngest wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent <= '0;
        end else if (load) begin
            ent.busy <= 1'b1;
            ent.age  <= ENT_W'(1);
            ent.lat  <= lat;
        end else if (ent.busy) begin
            if (ent.age == AGE_MAX) begin
                ent.busy <= 1'b0;
            end else begin
                ent.age <= ent.age + ENT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall and registered execute-stage forward selects from a per-register writer scoreboard.
module hazard_scoreboard
    import proc_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [NUM_SRC*REG_AW-1:0] src_reg,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic [REG_AW-1:0]         dst_reg,
    input  logic                      dst_we,
    input  logic [SEL_W-1:0]          dst_lat,
    input  logic                      flush,
    output logic                      stall,
    output logic                      issue_fire,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [31:0]               stall_cnt
);

    sb_entry_t                  ents [NUM_REGS];
    logic [ENT_W-1:0]           lat_clamped;
    logic [NUM_SRC-1:0]         hazard;
    logic [NUM_SRC*SEL_W-1:0]   fwd_next;

    always_comb begin
        lat_clamped = ENT_W'(dst_lat);
        if (dst_lat == '0 || lat_clamped > ENT_W'(NUM_FWD)) begin
            lat_clamped = ENT_W'(NUM_FWD);
        end
    end

    assign ents[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        sb_entry #(
            .NUM_FWD (NUM_FWD)
        ) u_ent (
            .clk  (clk),
            .rst  (rst),
            .load (issue_fire && dst_we && (dst_reg == REG_AW'(r))),
            .lat  (lat_clamped),
            .ent  (ents[r])
        );
    end

    // A busy writer is either not ready yet (stall) or already sitting in bypass stage 'age'.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] idx;
        sb_entry_t         e;
        logic              live;

        assign idx  = src_reg[i*REG_AW +: REG_AW];
        assign e    = ents[idx];
        assign live = src_used[i] && (idx != '0) && e.busy;

        assign hazard[i]                  = live && (e.age < e.lat);
        assign fwd_next[i*SEL_W +: SEL_W] = (live && !(e.age < e.lat)) ? SEL_W'(e.age) : '0;
    end

    assign stall      = issue_valid && !flush && (|hazard);
    assign issue_fire = issue_valid && !flush && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel <= '0;
        end else if (issue_fire) begin
            fwd_sel <= fwd_next;
        end else begin
            fwd_sel <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: default 2-stage bypass build plus a 3-stage build.
module tb_hazard_scoreboard;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        issue_valid = 1'b0;
    logic [9:0]  src_reg     = '0;
    logic [1:0]  src_used    = '0;
    logic [4:0]  dst_reg     = '0;
    logic        dst_we      = 1'b0;
    logic [1:0]  dst_lat     = '0;
    logic        flush       = 1'b0;
    logic        stall;
    logic        issue_fire;
    logic [3:0]  fwd_sel;
    logic [31:0] stall_cnt;

    logic        b_valid    = 1'b0;
    logic [9:0]  b_src_reg  = '0;
    logic [1:0]  b_src_used = '0;
    logic [4:0]  b_dst_reg  = '0;
    logic        b_dst_we   = 1'b0;
    logic [1:0]  b_dst_lat  = '0;
    logic        b_flush    = 1'b0;
    logic        b_stall;
    logic        b_fire;
    logic [3:0]  b_fwd_sel;
    logic [31:0] b_stall_cnt;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    logic [3:0]  exp_q [$];
    logic [3:0]  exp_fwd;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS(32), .REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .SEL_W(2)
    ) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .src_reg(src_reg),
        .src_used(src_used), .dst_reg(dst_reg), .dst_we(dst_we), .dst_lat(dst_lat),
        .flush(flush), .stall(stall), .issue_fire(issue_fire), .fwd_sel(fwd_sel),
        .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(
        .NUM_REGS(32), .REG_AW(5), .NUM_SRC(2), .NUM_FWD(3), .SEL_W(2)
    ) dut3 (
        .clk(clk), .rst(rst), .issue_valid(b_valid), .src_reg(b_src_reg),
        .src_used(b_src_used), .dst_reg(b_dst_reg), .dst_we(b_dst_we), .dst_lat(b_dst_lat),
        .flush(b_flush), .stall(b_stall), .issue_fire(b_fire), .fwd_sel(b_fwd_sel),
        .stall_cnt(b_stall_cnt)
    );

    task automatic set_in(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic [4:0] dst, input logic we,
                          input logic [1:0] lat, input logic fl);
        issue_valid = v;
        src_reg     = {s1, s0};
        src_used    = used;
        dst_reg     = dst;
        dst_we      = we;
        dst_lat     = lat;
        flush       = fl;
        #1;
    endtask

    // Expected select for the instruction in decode is queued now and retrieved once it reaches execute.
    task automatic tick(input logic [3:0] expect_sel);
        exp_q.push_back(expect_sel);
        @(posedge clk);
        #1;
        exp_fwd = exp_q.pop_front();
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < n; k++) tick(4'h0);
    endtask

    task automatic test_reset();
        #1;
        chk_cnt++; if (fwd_sel !== 4'h0) $display("FAIL reset_fwd got %h exp 0", fwd_sel); else pass_cnt++;
        chk_cnt++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", stall_cnt); else pass_cnt++;
        chk_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_fwd();
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'(LAT_ALU), 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk_cnt++; if (stall !== 1'b0) $display("FAIL alu_stall got %b exp 0", stall); else pass_cnt++;
        chk_cnt++; if (issue_fire !== 1'b1) $display("FAIL alu_fire got %b exp 1", issue_fire); else pass_cnt++;
        tick({2'd0, 2'(FWD_XM)});
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL alu_fwd got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        chk_cnt++; if (stall_cnt !== 32'd0) $display("FAIL alu_cnt got %0d exp 0", stall_cnt); else pass_cnt++;
        idle(3);
    endtask

    task automatic test_load_use();
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'(LAT_LOAD), 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0);
        chk_cnt++; if (stall !== 1'b1) $display("FAIL lu_stall1 got %b exp 1", stall); else pass_cnt++;
        chk_cnt++; if (issue_fire !== 1'b0) $display("FAIL lu_fire1 got %b exp 0", issue_fire); else pass_cnt++;
        tick(4'h0);
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL lu_bubble got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        chk_cnt++; if (stall_cnt !== 32'd1) $display("FAIL lu_cnt got %0d exp 1", stall_cnt); else pass_cnt++;
        chk_cnt++; if (stall !== 1'b0) $display("FAIL lu_stall2 got %b exp 0", stall); else pass_cnt++;
        tick({2'(FWD_MW), 2'd0});
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL lu_fwd got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        chk_cnt++; if (stall_cnt !== 32'd1) $display("FAIL lu_cnt2 got %0d exp 1", stall_cnt); else pass_cnt++;
        idle(3);
    endtask

    task automatic test_distance();
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'(LAT_ALU), 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk_cnt++; if (stall !== 1'b0) $display("FAIL d1_stall got %b exp 0", stall); else pass_cnt++;
        tick({2'd0, 2'(FWD_MW)});
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL d1_fwd got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'(LAT_ALU), 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0);
        tick(4'h0);
        tick(4'h0);
        set_in(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0);
        tick({2'(FWD_RF), 2'd0});
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL d2_fwd got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        idle(3);
    endtask

    task automatic test_r0_flush();
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'(LAT_LOAD), 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0);
        chk_cnt++; if (stall !== 1'b0) $display("FAIL r0_stall got %b exp 0", stall); else pass_cnt++;
        tick(4'h0);
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL r0_fwd got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'(LAT_LOAD), 1'b1);
        chk_cnt++; if (issue_fire !== 1'b0) $display("FAIL fl_fire got %b exp 0", issue_fire); else pass_cnt++;
        tick(4'h0);
        set_in(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk_cnt++; if (stall !== 1'b0) $display("FAIL fl_stall got %b exp 0", stall); else pass_cnt++;
        tick(4'h0);
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL fl_fwd got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        idle(3);
    endtask

    task automatic test_waw_reset();
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'(LAT_LOAD), 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'(LAT_ALU), 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk_cnt++; if (stall !== 1'b0) $display("FAIL waw_stall got %b exp 0", stall); else pass_cnt++;
        tick({2'd0, 2'(FWD_XM)});
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL waw_fwd got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        idle(3);
        set_in(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 2'(LAT_ALU), 1'b0);
        tick(4'h0);
        set_in(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 2'(LAT_LOAD), 1'b0);
        tick({2'd0, 2'(FWD_XM)});
        set_in(1'b1, 5'd0, 5'd9, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0);
        chk_cnt++; if (stall !== 1'b1) $display("FAIL pre_rst_stall got %b exp 1", stall); else pass_cnt++;
        #1;
        rst = 1'b0;
        #1;
        chk_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall); else pass_cnt++;
        chk_cnt++; if (fwd_sel !== 4'h0) $display("FAIL rst_fwd got %h exp 0", fwd_sel); else pass_cnt++;
        chk_cnt++; if (stall_cnt !== 32'd0) $display("FAIL rst_cnt got %0d exp 0", stall_cnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_in(1'b1, 5'd0, 5'd9, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0);
        chk_cnt++; if (stall !== 1'b0) $display("FAIL post_rst_stall got %b exp 0", stall); else pass_cnt++;
        tick(4'h0);
        chk_cnt++; if (fwd_sel !== exp_fwd) $display("FAIL post_rst_fwd got %h exp %h", fwd_sel, exp_fwd); else pass_cnt++;
        idle(3);
    endtask

    task automatic test_deep_fwd();
        b_valid = 1'b1; b_src_used = 2'b00; b_dst_reg = 5'd2; b_dst_we = 1'b1; b_dst_lat = 2'd3;
        @(posedge clk); #1;
        b_dst_we = 1'b0; b_dst_reg = 5'd0; b_dst_lat = 2'd0;
        b_src_reg = {5'd0, 5'd2}; b_src_used = 2'b01;
        #1;
        chk_cnt++; if (b_stall !== 1'b1) $display("FAIL deep_stall1 got %b exp 1", b_stall); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (b_stall !== 1'b1) $display("FAIL deep_stall2 got %b exp 1", b_stall); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (b_stall !== 1'b0) $display("FAIL deep_stall3 got %b exp 0", b_stall); else pass_cnt++;
        chk_cnt++; if (b_fire !== 1'b1) $display("FAIL deep_fire got %b exp 1", b_fire); else pass_cnt++;
        exp_q.push_back(4'h3);
        @(posedge clk); #1;
        exp_fwd = exp_q.pop_front();
        b_valid = 1'b0; b_src_used = 2'b00;
        chk_cnt++; if (b_fwd_sel !== exp_fwd) $display("FAIL deep_fwd got %h exp %h", b_fwd_sel, exp_fwd); else pass_cnt++;
        chk_cnt++; if (b_stall_cnt !== 32'd2) $display("FAIL deep_cnt got %0d exp 2", b_stall_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_distance();
        test_r0_flush();
        test_waw_reset();
        test_deep_fwd();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
